// File: rtl/card_reader_frontend.sv
// card_reader_frontend: deserialises parity-checked card frames into a FIFO
// and replays one queued request per clock to the lab access controller.
module card_reader_frontend #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int CW      = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cardValid,
    input  logic          cardData,
    input  logic          hold,
    output logic [4:0]    smartCode,
    output logic          lab,
    output logic [1:0]    mode,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          parityErr,
    output logic          frameErr,
    output logic          overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [4:0]    code_q, code_d;
    logic          lab_q, lab_d;
    logic [1:0]    mode_q, mode_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [8:0]    frame;
    logic          done, good, full, pop, push;

    always_comb begin
        // frame = {code[4:0], lab, mode[1:0], parity} on the completing strobe
        frame     = {shift_q, cardData};
        done      = (state_q == SHIFT) && cardValid && (bit_cnt_q == 4'd8);
        good      = done && !(^frame) && !frame[2];
        full      = pending_q == CW'(DEPTH);
        pop       = !hold && (pending_q != '0);
        push      = good && (!full || pop);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        shift_d   = shift_q;
        perr_d    = done && (^frame);
        ferr_d    = 1'b0;
        ovf_d     = good && full && !pop;
        if (state_q == IDLE) begin
            if (cardValid && cardData) begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
                tmo_d     = '0;
            end
        end else if (cardValid) begin
            shift_d   = frame[7:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            tmo_d     = '0;
            if (done) state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push) begin
            mem_d[wp_q] = frame[8:1];
            wp_d        = wp_q + 1'b1;
        end
        if (pop) rp_d = rp_q + 1'b1;
        pending_d = pending_q + CW'(push) - CW'(pop);
        code_d    = pop ? mem_q[rp_q][7:3] : 5'd0;
        lab_d     = pop & mem_q[rp_q][2];
        mode_d    = pop ? mem_q[rp_q][1:0] : 2'b10;
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            shift_q   <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            pending_q <= '0;
            code_q    <= '0;
            lab_q     <= 1'b0;
            mode_q    <= 2'b10;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            shift_q   <= shift_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            lab_q     <= lab_d;
            mode_q    <= mode_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign smartCode = code_q;
    assign lab       = lab_q;
    assign mode      = mode_q;
    assign pending   = pending_q;
    assign busy      = state_q == SHIFT;
    assign parityErr = perr_q;
    assign frameErr  = ferr_q;
    assign overflow  = ovf_q;
endmodule
